// File: rtl/display_scan_if.sv
// Purpose : bundles the display driver's data inputs and segment/digit outputs.
// Signals : digits_in/dp_in/blank_in/load - display value and capture strobe
//           seg_out/dp_out/dig_en         - shared segment bus and digit commons
//           frame_tick                    - pulse after each frame wrap
// Modports: master - the side supplying values (status logic / bench)
//           slave  - the display driver itself
interface display_scan_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  load;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic [N_DIGITS-1:0]   dig_en;
    logic                  frame_tick;

    modport master (
        output digits_in, dp_in, blank_in, load,
        input  seg_out, dp_out, dig_en, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, blank_in, load,
        output seg_out, dp_out, dig_en, frame_tick
    );
endinterface

// File: rtl/display_scan_driver.sv
// Purpose : multiplexed N-digit hex 7-segment driver with anti-ghost blanking,
//           per-digit decimal point / forced blank, optional leading-zero
//           suppression and frame-aligned double buffering of the display value.
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - display_scan_if.slave (inputs, load strobe, segment/digit outputs)
module display_scan_driver #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned DIG_ACT_LOW = 1,
    parameter int unsigned LZ_BLANK    = 0
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.slave  bus
);

    localparam int unsigned PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned NIB_W  = 4 * N_DIGITS;

    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
    localparam logic [PCNT_W-1:0]   BLANK_TH  = PCNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Inactive levels; XOR with these converts active-high patterns to pin polarity.
    localparam logic [6:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

    // Scan position
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Shadow (captured on load) and active (displayed) buffers
    logic [NIB_W-1:0]    shadow_digits_q, shadow_digits_d;
    logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [N_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
    logic                pending_q, pending_d;
    logic [NIB_W-1:0]    active_digits_q, active_digits_d;
    logic [N_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [N_DIGITS-1:0] active_blank_q, active_blank_d;

    // Registered outputs
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] dig_en_q, dig_en_d;
    logic                frame_tick_q, frame_tick_d;

    // Decode helpers
    logic                slot_end;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                lz_zero;
    logic                upper_zero;
    logic                slot_lit;
    logic [N_DIGITS-1:0] one_hot;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot end and frame wrap detection
    always_comb begin
        slot_end = (pcnt_q == PCNT_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
    end

    // Select the current digit's data; upper_zero tracks "this and all higher nibbles are 0"
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        lz_zero    = 1'b0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (active_digits_q[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx_q) begin
                cur_nib   = active_digits_q[4*i +: 4];
                cur_dp    = active_dp_q[i];
                cur_blank = active_blank_q[i];
                lz_zero   = upper_zero && (i != 0);
            end
        end
    end

    // Next-state: prescaler, digit index, double buffer and output decode
    always_comb begin
        pcnt_d          = pcnt_q;
        idx_d           = idx_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        shadow_blank_d  = shadow_blank_q;
        pending_d       = pending_q;
        active_digits_d = active_digits_q;
        active_dp_d     = active_dp_q;
        active_blank_d  = active_blank_q;
        seg_d           = SEG_OFF;
        dp_d            = DP_OFF;
        dig_en_d        = DIG_OFF;
        frame_tick_d    = wrap;
        slot_lit        = 1'b0;
        one_hot         = N_DIGITS'(1) << idx_q;

        if (slot_end) begin
            pcnt_d = '0;
            idx_d  = wrap ? '0 : idx_q + IDX_W'(1);
        end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end

        // A load on the wrap edge bypasses the shadow; otherwise the shadow is promoted.
        if (wrap) begin
            if (bus.load) begin
                active_digits_d = bus.digits_in;
                active_dp_d     = bus.dp_in;
                active_blank_d  = bus.blank_in;
            end else if (pending_q) begin
                active_digits_d = shadow_digits_q;
                active_dp_d     = shadow_dp_q;
                active_blank_d  = shadow_blank_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadow_digits_d = bus.digits_in;
            shadow_dp_d     = bus.dp_in;
            shadow_blank_d  = bus.blank_in;
            pending_d       = 1'b1;
        end

        slot_lit = (pcnt_q >= BLANK_TH) && !(cur_blank || ((LZ_BLANK != 0) && lz_zero));
        if (slot_lit) begin
            seg_d    = hex7(cur_nib) ^ SEG_OFF;
            dp_d     = cur_dp ^ DP_OFF;
            dig_en_d = one_hot ^ DIG_OFF;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q          <= '0;
            idx_q           <= '0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            shadow_blank_q  <= '0;
            pending_q       <= 1'b0;
            active_digits_q <= '0;
            active_dp_q     <= '0;
            active_blank_q  <= '0;
            seg_q           <= SEG_OFF;
            dp_q            <= DP_OFF;
            dig_en_q        <= DIG_OFF;
            frame_tick_q    <= 1'b0;
        end else begin
            pcnt_q          <= pcnt_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            shadow_blank_q  <= shadow_blank_d;
            pending_q       <= pending_d;
            active_digits_q <= active_digits_d;
            active_dp_q     <= active_dp_d;
            active_blank_q  <= active_blank_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            dig_en_q        <= dig_en_d;
            frame_tick_q    <= frame_tick_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: two instances (leading-zero suppression off/on)
// driven identically, checked against a frame-level reference model every cycle
// plus directed slot checks and hand-written multi-cycle sequences.
module tb_display_scan_driver;

    localparam int unsigned N     = 4;
    localparam int unsigned S     = 4;
    localparam int unsigned B     = 1;
    localparam int unsigned FRAME = N * S;
    localparam logic [11:0] OFF   = 12'hFFF;   // {seg=7F, dp=1, dig=F}

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } payload_t;

    typedef struct {
        payload_t    in;
        bit          lz;
        int unsigned digit;
        logic [11:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned e        = 0;       // edges since reset released
    payload_t    latest   = '0;      // most recent load since reset
    payload_t    frame_val = '0;     // value shown in the current frame

    always #5 clk = ~clk;

    display_scan_if #(.N_DIGITS(N)) bus0 ();
    display_scan_if #(.N_DIGITS(N)) bus1 ();

    display_scan_driver #(
        .N_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B),
        .SEG_ACT_LOW(1), .DIG_ACT_LOW(1), .LZ_BLANK(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    display_scan_driver #(
        .N_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B),
        .SEG_ACT_LOW(1), .DIG_ACT_LOW(1), .LZ_BLANK(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Expected {seg, dp, dig_en} after edge ee, given the frame's display value
    function automatic logic [11:0] model_out(input payload_t f, input int unsigned ee, input bit lz);
        int unsigned pc;
        int unsigned d;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [3:0]  dig;
        bit          blanked;
        pc      = (ee - 1) % S;
        d       = ((ee - 1) / S) % N;
        upper   = f.digits >> (4 * d);
        nib     = upper[3:0];
        blanked = f.blank[d] || (lz && d > 0 && upper == 16'h0);
        if (pc < B || blanked) return OFF;
        dig = ~(4'b0001 << d);
        return {~hex_ref(nib), ~f.dp[d], dig};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic logic [11:0] out0();
        return {bus0.seg_out, bus0.dp_out, bus0.dig_en};
    endfunction

    function automatic logic [11:0] out1();
        return {bus1.seg_out, bus1.dp_out, bus1.dig_en};
    endfunction

    // One clock: drive inputs, take the edge, advance the model, compare both DUTs
    task automatic step(input logic r, input logic ld, input payload_t v);
        logic [11:0] exp0;
        logic [11:0] exp1;
        logic        exp_tick;
        rst            = r;
        bus0.load      = ld;
        bus0.digits_in = v.digits;
        bus0.dp_in     = v.dp;
        bus0.blank_in  = v.blank;
        bus1.load      = ld;
        bus1.digits_in = v.digits;
        bus1.dp_in     = v.dp;
        bus1.blank_in  = v.blank;
        @(posedge clk);
        #1;
        if (r) begin
            e         = 0;
            latest    = '0;
            frame_val = '0;
            exp0      = OFF;
            exp1      = OFF;
            exp_tick  = 1'b0;
        end else begin
            e++;
            exp0     = model_out(frame_val, e, 1'b0);
            exp1     = model_out(frame_val, e, 1'b1);
            exp_tick = (e % FRAME == 0);
            if (ld) latest = v;
            if (e % FRAME == 0) frame_val = latest;
        end
        chk("model_out_lz0", 32'(out0()), 32'(exp0));
        chk("model_out_lz1", 32'(out1()), 32'(exp1));
        chk("model_tick_lz0", 32'(bus0.frame_tick), 32'(exp_tick));
        chk("model_tick_lz1", 32'(bus1.frame_tick), 32'(exp_tick));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0);
    endtask

    task automatic load(input logic [15:0] d);
        payload_t v;
        v        = '0;
        v.digits = d;
        step(1'b0, 1'b1, v);
    endtask

    task automatic run_to(input int unsigned target);
        while (e < target) idle();
    endtask

    task automatic do_reset(input int unsigned cycles);
        for (int i = 0; i < int'(cycles); i++) begin
            step(1'b1, 1'b0, '0);
            chk("reset_out", 32'(out0()), 32'(OFF));
            chk("reset_tick", 32'(bus0.frame_tick), 32'd0);
        end
    endtask

    vec_t vt [17];

    initial begin
        payload_t p;

        vt[0]  = '{'{16'h1234, 4'h0, 4'h0}, 1'b0, 0, {7'h19, 1'b1, 4'b1110}};
        vt[1]  = '{'{16'h1234, 4'h0, 4'h0}, 1'b0, 1, {7'h30, 1'b1, 4'b1101}};
        vt[2]  = '{'{16'h1234, 4'h0, 4'h0}, 1'b0, 2, {7'h24, 1'b1, 4'b1011}};
        vt[3]  = '{'{16'h1234, 4'h0, 4'h0}, 1'b0, 3, {7'h79, 1'b1, 4'b0111}};
        vt[4]  = '{'{16'hABCD, 4'h0, 4'h0}, 1'b0, 0, {7'h21, 1'b1, 4'b1110}};
        vt[5]  = '{'{16'hABCD, 4'h0, 4'h0}, 1'b0, 3, {7'h08, 1'b1, 4'b0111}};
        vt[6]  = '{'{16'h0050, 4'h0, 4'h0}, 1'b1, 3, OFF};
        vt[7]  = '{'{16'h0050, 4'h0, 4'h0}, 1'b1, 2, OFF};
        vt[8]  = '{'{16'h0050, 4'h0, 4'h0}, 1'b1, 1, {7'h12, 1'b1, 4'b1101}};
        vt[9]  = '{'{16'h0050, 4'h0, 4'h0}, 1'b1, 0, {7'h40, 1'b1, 4'b1110}};
        vt[10] = '{'{16'h0000, 4'h0, 4'h0}, 1'b1, 0, {7'h40, 1'b1, 4'b1110}};
        vt[11] = '{'{16'h0000, 4'h0, 4'h0}, 1'b1, 1, OFF};
        vt[12] = '{'{16'h0000, 4'h0, 4'h0}, 1'b0, 1, {7'h40, 1'b1, 4'b1101}};
        vt[13] = '{'{16'h1234, 4'h4, 4'h0}, 1'b0, 2, {7'h24, 1'b0, 4'b1011}};
        vt[14] = '{'{16'h1234, 4'h0, 4'h2}, 1'b0, 1, OFF};
        vt[15] = '{'{16'h1234, 4'h1, 4'h1}, 1'b0, 0, OFF};
        vt[16] = '{'{16'h1005, 4'h0, 4'h0}, 1'b1, 1, {7'h40, 1'b1, 4'b1101}};

        bus0.load = 1'b0; bus0.digits_in = '0; bus0.dp_in = '0; bus0.blank_in = '0;
        bus1.load = 1'b0; bus1.digits_in = '0; bus1.dp_in = '0; bus1.blank_in = '0;

        // Reset held three cycles: everything dark, no tick
        do_reset(3);

        // Table: load at edge 2, check the blanking cycle and a lit cycle of one slot in frame 1
        for (int i = 0; i < 17; i++) begin
            int unsigned target;
            do_reset(1);
            idle();
            step(1'b0, 1'b1, vt[i].in);
            target = FRAME + S * vt[i].digit + 2;
            run_to(target - 1);
            chk($sformatf("vec%0d_dark", i), 32'(vt[i].lz ? out1() : out0()), 32'(OFF));
            run_to(target);
            chk($sformatf("vec%0d_lit", i), 32'(vt[i].lz ? out1() : out0()), 32'(vt[i].exp));
        end

        // Mid-frame load does not disturb the frame being shown
        do_reset(1);
        idle();
        load(16'h1234);
        run_to(19);
        load(16'hABCD);
        run_to(22); chk("midframe_d1", 32'(out0()), 32'({7'h30, 1'b1, 4'b1101}));
        run_to(26); chk("midframe_d2", 32'(out0()), 32'({7'h24, 1'b1, 4'b1011}));
        run_to(30); chk("midframe_d3", 32'(out0()), 32'({7'h79, 1'b1, 4'b0111}));
        run_to(32); chk("midframe_tick", 32'(bus0.frame_tick), 32'd1);
        run_to(34); chk("midframe_next_d0", 32'(out0()), 32'({7'h21, 1'b1, 4'b1110}));

        // Load coincident with the wrap edge wins over the pending shadow
        do_reset(1);
        idle();
        load(16'h1234);
        run_to(15);
        load(16'h00FF);
        run_to(18); chk("wrapload_d0", 32'(out0()), 32'({7'h0E, 1'b1, 4'b1110}));
        run_to(22); chk("wrapload_d1", 32'(out0()), 32'({7'h0E, 1'b1, 4'b1101}));
        run_to(26); chk("wrapload_d2", 32'(out0()), 32'({7'h40, 1'b1, 4'b1011}));
        run_to(30); chk("wrapload_d3", 32'(out0()), 32'({7'h40, 1'b1, 4'b0111}));

        // Reset during digit 2 slot with a pending load discards it
        do_reset(1);
        idle();
        load(16'h1234);
        run_to(25);
        load(16'hABCD);
        do_reset(2);
        idle(); chk("rstmid_first_dark", 32'(out0()), 32'(OFF));
        idle(); chk("rstmid_d0_zero", 32'(out0()), 32'({7'h40, 1'b1, 4'b1110}));
        run_to(16); chk("rstmid_tick", 32'(bus0.frame_tick), 32'd1);
        run_to(18); chk("rstmid_no_pending", 32'(out0()), 32'({7'h40, 1'b1, 4'b1110}));

        // Randomized traffic with occasional resets, checked against the model each cycle
        do_reset(1);
        for (int c = 0; c < 2500; c++) begin
            logic r;
            logic ld;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 4; k++)
                p.digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            p.dp    = 4'($urandom);
            p.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step(r, ld, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
